// File: rtl/fa16_lookup_ctrl_pkg.sv
// Shared types for the 16-way fully-associative lookup controller.
// FSM encoding and way count.
package fa16_lookup_ctrl_pkg;

  localparam int NUM_WAYS = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/fa16_match.sv
// Tag compare array with lowest-index one-hot of matches and of
// invalid ways.
module fa16_match
  import fa16_lookup_ctrl_pkg::*;
#(
  parameter int TAG_W = 20
) (
  input  logic [NUM_WAYS-1:0]            valid,
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]               tag,
  output logic [NUM_WAYS-1:0]            match_vec,
  output logic [NUM_WAYS-1:0]            match_oh,
  output logic [NUM_WAYS-1:0]            inv_oh
);

  logic [NUM_WAYS-1:0] inv;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      match_vec[i] = valid[i] && (tags[i] == tag);
    end
  end

  // x & -x isolates the lowest set bit
  assign inv      = ~valid;
  assign match_oh = match_vec & (~match_vec + NUM_WAYS'(1));
  assign inv_oh   = inv & (~inv + NUM_WAYS'(1));

endmodule

// File: rtl/fa16_lookup_ctrl.sv
// 16-entry fully-associative tag/data store with refill control.
// Optional perf counters under FA16_PERF_CNT_EN.
module fa16_lookup_ctrl
  import fa16_lookup_ctrl_pkg::*;
#(
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lookup_valid,
  output logic                lookup_ready,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [DATA_W-1:0]   resp_data,
  output logic                refill_req_valid,
  input  logic                refill_req_ready,
  output logic [TAG_W-1:0]    refill_req_tag,
  input  logic                refill_resp_valid,
  input  logic [DATA_W-1:0]   refill_resp_data,
  input  logic                flush,
  output logic                plru_hit,
  output logic [NUM_WAYS-1:0] plru_hit_sel,
  output logic                plru_wen,
  input  logic [NUM_WAYS-1:0] plru_victim
`ifdef FA16_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hit_cnt,
  output logic [31:0]         perf_miss_cnt
`endif
);

  state_e state_q, state_d;

  logic [NUM_WAYS-1:0]             valid_q;
  logic [NUM_WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [NUM_WAYS-1:0][DATA_W-1:0] data_q;
  logic                            flush_pend_q;

  logic [NUM_WAYS-1:0] match_vec;
  logic [NUM_WAYS-1:0] match_oh;
  logic [NUM_WAYS-1:0] inv_oh;
  logic [NUM_WAYS-1:0] wr_oh;
  logic [DATA_W-1:0]   hit_data;
  logic                any_match;
  logic                any_inv;
  logic                fire;
  logic                hit_fire;
  logic                miss_fire;
  logic                refill_fire;
  logic                clr_valid;

  fa16_match #(
    .TAG_W(TAG_W)
  ) u_match (
    .valid    (valid_q),
    .tags     (tag_q),
    .tag      (lookup_tag),
    .match_vec(match_vec),
    .match_oh (match_oh),
    .inv_oh   (inv_oh)
  );

  assign any_match   = |match_vec;
  assign any_inv     = |inv_oh;
  assign lookup_ready = (state_q == S_IDLE) && !flush;
  assign fire        = lookup_valid && lookup_ready;
  assign hit_fire    = fire && any_match;
  assign miss_fire   = fire && !any_match;
  assign refill_fire = (state_q == S_WAIT) && refill_resp_valid;

  assign refill_req_valid = (state_q == S_REQ);
  assign resp_valid       = (state_q == S_RESP);

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (match_oh[i]) hit_data = hit_data | data_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    plru_hit     = 1'b0;
    plru_hit_sel = '0;
    plru_wen     = 1'b0;
    wr_oh        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (hit_fire) begin
          plru_hit     = 1'b1;
          plru_hit_sel = match_oh;
          state_d      = S_RESP;
        end else if (miss_fire) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (refill_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (refill_resp_valid) begin
          state_d = S_RESP;
          if (any_inv) begin
            plru_hit     = 1'b1;
            plru_hit_sel = inv_oh;
            wr_oh        = inv_oh;
          end else begin
            plru_wen = 1'b1;
            wr_oh    = plru_victim;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A pending flush also wipes the way refilled by this transaction
  assign clr_valid =
    ((state_q == S_IDLE) && flush) ||
    ((state_q == S_RESP) && (flush || flush_pend_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      flush_pend_q   <= 1'b0;
      resp_hit       <= 1'b0;
      resp_data      <= '0;
      refill_req_tag <= '0;
    end else begin
      state_q <= state_d;
      if (clr_valid) valid_q <= '0;
      else           valid_q <= valid_q | wr_oh;
      if (state_q == S_RESP)
        flush_pend_q <= 1'b0;
      else if (flush && (state_q != S_IDLE))
        flush_pend_q <= 1'b1;
      if (hit_fire) begin
        resp_hit  <= 1'b1;
        resp_data <= hit_data;
      end else if (refill_fire) begin
        resp_hit  <= 1'b0;
        resp_data <= refill_resp_data;
      end
      if (miss_fire) refill_req_tag <= lookup_tag;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (wr_oh[i]) begin
        tag_q[i]  <= refill_req_tag;
        data_q[i] <= refill_resp_data;
      end
    end
  end

`ifdef FA16_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (flush) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (hit_fire && (perf_hit_cnt != '1))
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (miss_fire && (perf_miss_cnt != '1))
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fa16_lookup_ctrl.sv
// Bench for fa16_lookup_ctrl: directed table, corner sequences and
// random traffic against an array-based store model.
module tb_fa16_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [19:0] lookup_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_data;
  logic        refill_req_valid;
  logic        refill_req_ready;
  logic [19:0] refill_req_tag;
  logic        refill_resp_valid;
  logic [31:0] refill_resp_data;
  logic        flush;
  logic        plru_hit;
  logic [15:0] plru_hit_sel;
  logic        plru_wen;
  logic [15:0] plru_victim;
`ifdef FA16_PERF_CNT_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  fa16_lookup_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_valid     (lookup_valid),
    .lookup_ready     (lookup_ready),
    .lookup_tag       (lookup_tag),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_data        (resp_data),
    .refill_req_valid (refill_req_valid),
    .refill_req_ready (refill_req_ready),
    .refill_req_tag   (refill_req_tag),
    .refill_resp_valid(refill_resp_valid),
    .refill_resp_data (refill_resp_data),
    .flush            (flush),
    .plru_hit         (plru_hit),
    .plru_hit_sel     (plru_hit_sel),
    .plru_wen         (plru_wen),
    .plru_victim      (plru_victim)
`ifdef FA16_PERF_CNT_EN
    ,
    .perf_hit_cnt     (perf_hit_cnt),
    .perf_miss_cnt    (perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // store model: plain arrays of entries
  bit          m_valid[16];
  logic [19:0] m_tag[16];
  logic [31:0] m_data[16];

  typedef struct {
    logic [19:0] tag;
    logic [31:0] rdata;
    logic [15:0] vic;
    int          dly;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_find(input logic [19:0] t);
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int m_first_inv();
    for (int i = 0; i < 16; i++)
      if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic txn(input logic [19:0] tag, input logic [31:0] rdata,
                     input logic [15:0] vic, input int dly,
                     input bit fl_wait,
                     output bit hit, output logic [31:0] data);
    int w;
    int inv;
    logic [15:0] one;
    one = 16'h0001;
    w = m_find(tag);
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_tag   = tag;
    #1;
    chk("lookup_ready", lookup_ready, 1);
    if (w >= 0) begin
      chk("hit_plru_hit", plru_hit, 1);
      chk("hit_sel", plru_hit_sel, one << w);
      chk("hit_wen", plru_wen, 0);
      @(negedge clk);
      lookup_valid = 1'b0;
      #1;
      chk("hit_resp_valid", resp_valid, 1);
      chk("hit_resp_hit", resp_hit, 1);
      chk("hit_resp_data", resp_data, m_data[w]);
    end else begin
      chk("miss_plru_hit", plru_hit, 0);
      @(negedge clk);
      lookup_valid = 1'b0;
      #1;
      for (int k = 0; k <= dly; k++) begin
        chk("req_valid", refill_req_valid, 1);
        chk("req_tag", refill_req_tag, tag);
        chk("req_lookup_ready", lookup_ready, 0);
        refill_req_ready = (k == dly);
        @(negedge clk);
        #1;
      end
      refill_req_ready = 1'b0;
      chk("wait_req_valid", refill_req_valid, 0);
      chk("wait_resp_valid", resp_valid, 0);
      if (fl_wait) begin
        flush = 1'b1;
        @(negedge clk);
        #1;
        flush = 1'b0;
      end
      refill_resp_valid = 1'b1;
      refill_resp_data  = rdata;
      plru_victim       = vic;
      #1;
      inv = m_first_inv();
      if (inv >= 0) begin
        chk("fill_plru_hit", plru_hit, 1);
        chk("fill_sel", plru_hit_sel, one << inv);
        chk("fill_wen", plru_wen, 0);
        m_valid[inv] = 1'b1;
        m_tag[inv]   = tag;
        m_data[inv]  = rdata;
      end else begin
        chk("evict_wen", plru_wen, 1);
        chk("evict_plru_hit", plru_hit, 0);
        for (int i = 0; i < 16; i++)
          if (vic[i]) begin
            m_tag[i]  = tag;
            m_data[i] = rdata;
          end
      end
      @(negedge clk);
      refill_resp_valid = 1'b0;
      plru_victim       = '0;
      #1;
      chk("miss_resp_valid", resp_valid, 1);
      chk("miss_resp_hit", resp_hit, 0);
      chk("miss_resp_data", resp_data, rdata);
      if (fl_wait) m_clear();
    end
    hit  = resp_hit;
    data = resp_data;
    @(negedge clk);
    #1;
    chk("resp_one_cycle", resp_valid, 0);
  endtask

  bit          h;
  logic [31:0] d;

  initial begin
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    lookup_tag = '0;
    refill_req_ready = 1'b0;
    refill_resp_valid = 1'b0;
    refill_resp_data = '0;
    flush = 1'b0;
    plru_victim = '0;
    m_clear();

    tbl[0] = '{20'h12345, 32'hDEADBEEF, 16'h0, 0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{20'h12345, 32'h0, 16'h0, 0, 1'b1, 32'hDEADBEEF};
    for (int i = 1; i <= 15; i++)
      tbl[i+1] = '{20'h00100 + 20'(i), 32'hA0000000 + 32'(i),
                   16'h0, i % 3, 1'b0, 32'hA0000000 + 32'(i)};
    tbl[17] = '{20'h77777, 32'h55555555, 16'h0100, 5, 1'b0, 32'h55555555};
    tbl[18] = '{20'h00108, 32'hA5000008, 16'h0200, 1, 1'b0, 32'hA5000008};
    tbl[19] = '{20'h77777, 32'h0, 16'h0, 0, 1'b1, 32'h55555555};
    tbl[20] = '{20'h12345, 32'h0, 16'h0, 0, 1'b1, 32'hDEADBEEF};
    tbl[21] = '{20'h00109, 32'hA5000009, 16'h0001, 2, 1'b0, 32'hA5000009};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_req_valid", refill_req_valid, 0);
    chk("rst_req_tag", refill_req_tag, 0);
    chk("rst_plru_hit", plru_hit, 0);
    chk("rst_plru_wen", plru_wen, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      txn(tbl[i].tag, tbl[i].rdata, tbl[i].vic, tbl[i].dly, 1'b0, h, d);
      chk("tbl_hit", h, tbl[i].exp_hit);
      chk("tbl_data", d, tbl[i].exp_data);
    end

    // flush in IDLE blocks the lookup and clears the store
    @(negedge clk);
    flush = 1'b1;
    lookup_valid = 1'b1;
    lookup_tag = 20'h77777;
    #1;
    chk("flush_idle_ready", lookup_ready, 0);
    chk("flush_idle_plru", plru_hit, 0);
    @(negedge clk);
    flush = 1'b0;
    lookup_valid = 1'b0;
    #1;
    chk("flush_idle_resp", resp_valid, 0);
    chk("flush_idle_req", refill_req_valid, 0);
    m_clear();
    txn(20'h77777, 32'h11112222, 16'h0, 0, 1'b0, h, d);
    chk("post_flush_miss", h, 0);
    txn(20'h12345, 32'h33334444, 16'h0, 0, 1'b0, h, d);
    chk("post_flush_miss2", h, 0);

    // flush during WAIT: response delivered, then everything misses
    txn(20'h0ABCD, 32'hCAFEF00D, 16'h0, 1, 1'b1, h, d);
    chk("flush_wait_data", d, 32'hCAFEF00D);
    txn(20'h0ABCD, 32'h1, 16'h0, 0, 1'b0, h, d);
    chk("flush_wait_refilled_miss", h, 0);
    txn(20'h77777, 32'h2, 16'h0, 0, 1'b0, h, d);
    chk("flush_wait_prior_miss", h, 0);

    // reset during WAIT, then a stray refill response
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_tag = 20'hBEEF1;
    @(negedge clk);
    lookup_valid = 1'b0;
    refill_req_ready = 1'b1;
    @(negedge clk);
    refill_req_ready = 1'b0;
    #1;
    chk("pre_rst_wait", refill_req_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", lookup_ready, 1);
    chk("mid_rst_req", refill_req_valid, 0);
    chk("mid_rst_data", resp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    refill_resp_valid = 1'b1;
    refill_resp_data = 32'hBAD0BAD0;
    plru_victim = 16'h0001;
    #1;
    chk("stray_plru_hit", plru_hit, 0);
    chk("stray_plru_wen", plru_wen, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("stray_resp_valid", resp_valid, 0);
    end
    refill_resp_valid = 1'b0;
    plru_victim = '0;
    m_clear();
    txn(20'h12345, 32'h0F0F0F0F, 16'h0, 0, 1'b0, h, d);
    chk("post_rst_miss", h, 0);
    txn(20'h0ABCD, 32'h5, 16'h0, 0, 1'b0, h, d);
    chk("post_rst_miss2", h, 0);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [19:0] t;
      logic [15:0] v;
      int r;
      t = 20'h40000 + 20'($urandom_range(0, 23));
      r = $urandom_range(0, 16);
      v = (r == 16) ? 16'h0 : (16'h0001 << r);
      txn(t, $urandom, v, $urandom_range(0, 3),
          ($urandom_range(0, 19) == 0), h, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
